// File: rtl/in_chunk_dispatcher.sv
// Input chunk dispatcher: captures a 4-word PPS, then deals frame words round-robin to slices in chunks.
// Latency 1 cycle in_valid -> out_valid/pps_valid; no backpressure, a word for a non-ready slice is dropped and flags overflow.
// Optional per-slice dispatched-word counters with IN_DISPATCH_STATS_EN.
module in_chunk_dispatcher #(
  parameter int MAX_NBR_SLICES = 2,
  parameter int CHUNK_W        = 12
) (
  input  logic                                   clk_in_int,
  input  logic                                   rst_n,
  input  logic                                   flush,
  input  logic [255:0]                           in_data,
  input  logic                                   in_valid,
  input  logic                                   in_sof,
  input  logic [CHUNK_W-1:0]                     cfg_chunk_words,
  input  logic [$clog2(MAX_NBR_SLICES+1)-1:0]    cfg_nbr_slices,
  output logic [1023:0]                          pps_out,
  output logic                                   pps_valid,
  output logic [255:0]                           out_data,
  output logic [MAX_NBR_SLICES-1:0]              out_valid,
  input  logic [MAX_NBR_SLICES-1:0]              out_ready,
  output logic                                   overflow
`ifdef IN_DISPATCH_STATS_EN
  , output logic [MAX_NBR_SLICES*32-1:0]         words_cnt
`endif
);

  localparam int NBR_W = $clog2(MAX_NBR_SLICES+1);

  typedef enum logic [1:0] {PPS_CAP, WAIT_SOF, DATA} state_t;

  state_t              state;
  logic [1:0]          pps_cnt;
  logic [CHUNK_W-1:0]  word_cnt;
  logic [CHUNK_W-1:0]  chunk_words;
  logic [NBR_W-1:0]    slice_idx;
  logic [NBR_W-1:0]    nbr_slices;

  logic                      dispatch;
  logic                      rdy;
  logic [CHUNK_W-1:0]        chunk_cfg, chunk_eff, wc_base, wc_nxt;
  logic [NBR_W-1:0]          nbr_cfg, nbr_eff, tgt, slice_nxt;
  logic [MAX_NBR_SLICES-1:0] onehot;

  // An SOF word starts the frame with freshly clamped config, before it is latched.
  always_comb begin
    chunk_cfg = (cfg_chunk_words == '0) ? CHUNK_W'(1) : cfg_chunk_words;
    nbr_cfg   = (cfg_nbr_slices == '0 || cfg_nbr_slices > NBR_W'(MAX_NBR_SLICES))
                ? NBR_W'(MAX_NBR_SLICES) : cfg_nbr_slices;
    chunk_eff = in_sof ? chunk_cfg : chunk_words;
    nbr_eff   = in_sof ? nbr_cfg : nbr_slices;
    tgt       = in_sof ? '0 : slice_idx;
    wc_base   = in_sof ? '0 : word_cnt;
    wc_nxt    = wc_base + CHUNK_W'(1);
    slice_nxt = tgt;
    if (wc_base == chunk_eff - CHUNK_W'(1)) begin
      wc_nxt    = '0;
      slice_nxt = (tgt == nbr_eff - NBR_W'(1)) ? '0 : tgt + NBR_W'(1);
    end
    for (int i = 0; i < MAX_NBR_SLICES; i++) onehot[i] = (tgt == NBR_W'(i));
    rdy      = |(onehot & out_ready);
    dispatch = in_valid && !flush &&
               (state == DATA || (state == WAIT_SOF && in_sof));
  end

  always_ff @(posedge clk_in_int or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PPS_CAP;
      pps_cnt     <= '0;
      word_cnt    <= '0;
      chunk_words <= '0;
      slice_idx   <= '0;
      nbr_slices  <= '0;
      pps_out     <= '0;
      pps_valid   <= 1'b0;
      out_data    <= '0;
      out_valid   <= '0;
      overflow    <= 1'b0;
    end else begin
      out_valid <= '0;
      pps_valid <= 1'b0;
      if (flush) begin
        state     <= PPS_CAP;
        pps_cnt   <= '0;
        word_cnt  <= '0;
        slice_idx <= '0;
        overflow  <= 1'b0;
      end else if (in_valid && state == PPS_CAP) begin
        pps_out[{pps_cnt, 8'h00} +: 256] <= in_data;
        pps_cnt <= pps_cnt + 2'd1;
        if (pps_cnt == 2'd3) begin
          state     <= WAIT_SOF;
          pps_valid <= 1'b1;
        end
      end else if (dispatch) begin
        if (in_sof) begin
          state       <= DATA;
          chunk_words <= chunk_cfg;
          nbr_slices  <= nbr_cfg;
        end
        word_cnt  <= wc_nxt;
        slice_idx <= slice_nxt;
        if (rdy) begin
          out_data  <= in_data;
          out_valid <= onehot;
        end else begin
          overflow  <= 1'b1;
        end
      end
    end
  end

`ifdef IN_DISPATCH_STATS_EN
  logic [31:0] stat_q [MAX_NBR_SLICES];

  always_ff @(posedge clk_in_int or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_NBR_SLICES; i++) stat_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < MAX_NBR_SLICES; i++) stat_q[i] <= '0;
    end else if (dispatch) begin
      for (int i = 0; i < MAX_NBR_SLICES; i++) begin
        if (in_sof)
          stat_q[i] <= (rdy && onehot[i]) ? 32'd1 : 32'd0;
        else if (rdy && onehot[i] && stat_q[i] != '1)
          stat_q[i] <= stat_q[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < MAX_NBR_SLICES; g++) begin : g_stat
    assign words_cnt[g*32 +: 32] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_in_chunk_dispatcher.sv
// Randomized bench for in_chunk_dispatcher against a frame-position reference model.
module tb_in_chunk_dispatcher;
  localparam int MAX = 2;
  localparam int CW  = 12;

  logic           clk_in_int = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic [255:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_sof = 1'b0;
  logic [CW-1:0]  cfg_chunk_words = '0;
  logic [1:0]     cfg_nbr_slices = '0;
  logic [1023:0]  pps_out;
  logic           pps_valid;
  logic [255:0]   out_data;
  logic [MAX-1:0] out_valid;
  logic [MAX-1:0] out_ready = '1;
  logic           overflow;
`ifdef IN_DISPATCH_STATS_EN
  logic [MAX*32-1:0] words_cnt;
`endif

  in_chunk_dispatcher #(.MAX_NBR_SLICES(MAX), .CHUNK_W(CW)) dut (
    .clk_in_int(clk_in_int), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .cfg_chunk_words(cfg_chunk_words), .cfg_nbr_slices(cfg_nbr_slices),
    .pps_out(pps_out), .pps_valid(pps_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow)
`ifdef IN_DISPATCH_STATS_EN
    , .words_cnt(words_cnt)
`endif
  );

  always #5 clk_in_int = ~clk_in_int;

  int total = 0;
  int bad   = 0;

  // Reference model: slice = (frame word index / chunk) mod slices.
  int             m_pps;
  bit             m_in_frame;
  int             m_n, m_c, m_s;
  logic [1023:0]  m_pps_out;
  logic [255:0]   m_data;
  logic [MAX-1:0] m_vld;
  bit             m_ovf, m_ppsv;

  task automatic model_reset();
    m_pps = 0; m_in_frame = 0; m_n = 0; m_c = 1; m_s = MAX;
    m_pps_out = '0; m_data = '0; m_vld = '0; m_ovf = 0; m_ppsv = 0;
  endtask

  task automatic model_step(input logic f, input logic v, input logic s,
                            input logic [255:0] d, input logic [MAX-1:0] rdy);
    int sl;
    m_vld = '0; m_ppsv = 0;
    if (f) begin
      m_pps = 0; m_in_frame = 0; m_ovf = 0;
    end else if (v) begin
      if (m_pps < 4) begin
        m_pps_out[m_pps*256 +: 256] = d;
        m_pps++;
        if (m_pps == 4) m_ppsv = 1;
      end else if (s || m_in_frame) begin
        if (s) begin
          m_in_frame = 1; m_n = 0;
          m_c = (cfg_chunk_words == 0) ? 1 : int'(cfg_chunk_words);
          m_s = (cfg_nbr_slices == 0 || cfg_nbr_slices > MAX) ? MAX : int'(cfg_nbr_slices);
        end
        sl = (m_n / m_c) % m_s;
        m_n++;
        if (rdy[sl]) begin
          m_vld[sl] = 1'b1; m_data = d;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  logic [MAX-1:0] obs_vld;
  logic           obs_ovf;

  task automatic cycle(input logic f, input logic v, input logic s,
                       input logic [255:0] d, input logic [MAX-1:0] rdy);
    flush = f; in_valid = v; in_sof = s; in_data = d; out_ready = rdy;
    model_step(f, v, s, d, rdy);
    @(posedge clk_in_int); #1;
    flush = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    obs_vld = out_valid; obs_ovf = overflow;
    total++;
    if (out_valid !== m_vld) begin
      bad++; $display("FAIL out_valid: got %b want %b t=%0t", out_valid, m_vld, $time);
    end
    total++;
    if (overflow !== m_ovf) begin
      bad++; $display("FAIL overflow: got %b want %b t=%0t", overflow, m_ovf, $time);
    end
    total++;
    if (pps_valid !== m_ppsv) begin
      bad++; $display("FAIL pps_valid: got %b want %b t=%0t", pps_valid, m_ppsv, $time);
    end
    total++;
    if (pps_out !== m_pps_out) begin
      bad++; $display("FAIL pps_out: got %h want %h", pps_out, m_pps_out);
    end
    if (m_vld != '0) begin
      total++;
      if (out_data !== m_data) begin
        bad++; $display("FAIL out_data: got %h want %h", out_data, m_data);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if (out_valid !== '0 || overflow !== 1'b0 || pps_valid !== 1'b0 ||
        out_data !== '0 || pps_out !== '0) begin
      bad++;
      $display("FAIL %s: vld=%b ovf=%b ppsv=%b data_nz=%b pps_nz=%b want all zero",
               tag, out_valid, overflow, pps_valid, |out_data, |pps_out);
    end
  endtask

  task automatic send_pps(input logic [255:0] base);
    for (int i = 1; i <= 4; i++) cycle(0, 1, 0, base + 256'(i), '1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset_state");
    @(posedge clk_in_int); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_pps();
    logic [255:0] w;
    cycle(1, 0, 0, '0, '1);
    for (int i = 1; i <= 4; i++) begin
      w = 256'(i);
      cycle(0, 1, 0, w, '1);
      total++;
      if (pps_valid !== (i == 4)) begin
        bad++; $display("FAIL pps_pulse_w%0d: got %b want %b", i, pps_valid, i == 4);
      end
    end
    cycle(0, 0, 0, '0, '1);
    total++;
    if (pps_valid !== 1'b0) begin
      bad++; $display("FAIL pps_single_pulse: got %b want 0", pps_valid);
    end
    for (int i = 0; i < 4; i++) begin
      w = 256'(i + 1);
      total++;
      if (pps_out[i*256 +: 256] !== w) begin
        bad++; $display("FAIL pps_slot%0d: got %h want %h", i, pps_out[i*256 +: 256], w);
      end
    end
  endtask

  task automatic test_dispatch();
    logic [MAX-1:0] pat [12];
    pat = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10,
            2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    cfg_chunk_words = 12'd3; cfg_nbr_slices = 2'd2;
    cycle(0, 1, 0, 256'hdead, '1);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, i == 0, 256'(32'h1000 + i), '1);
      total++;
      if (obs_vld !== pat[i]) begin
        bad++; $display("FAIL dispatch_w%0d: got %b want %b", i, obs_vld, pat[i]);
      end
    end
  endtask

  task automatic test_clamp();
    logic [MAX-1:0] exp;
    cfg_chunk_words = '0; cfg_nbr_slices = '0;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      cycle(0, 1, i == 0, 256'(32'h2000 + i), '1);
      total++;
      if (obs_vld !== exp) begin
        bad++; $display("FAIL clamp_w%0d: got %b want %b", i, obs_vld, exp);
      end
    end
  endtask

  task automatic test_overflow();
    cfg_chunk_words = 12'd2; cfg_nbr_slices = 2'd2;
    cycle(0, 1, 1, 256'h3000, 2'b01);
    cycle(0, 1, 0, 256'h3001, 2'b01);
    cycle(0, 1, 0, 256'h3002, 2'b01);
    total++;
    if (obs_vld !== 2'b00 || obs_ovf !== 1'b1) begin
      bad++; $display("FAIL overflow_drop: got vld=%b ovf=%b want vld=00 ovf=1", obs_vld, obs_ovf);
    end
    cycle(0, 1, 0, 256'h3003, 2'b01);
    cycle(0, 1, 0, 256'h3004, 2'b01);
    total++;
    if (obs_vld !== 2'b01 || obs_ovf !== 1'b1) begin
      bad++; $display("FAIL overflow_next_chunk: got vld=%b ovf=%b want vld=01 ovf=1", obs_vld, obs_ovf);
    end
  endtask

  task automatic test_flush();
    cycle(1, 1, 0, 256'h4000, '1);
    total++;
    if (obs_vld !== 2'b00 || obs_ovf !== 1'b0) begin
      bad++; $display("FAIL flush_drop: got vld=%b ovf=%b want vld=00 ovf=0", obs_vld, obs_ovf);
    end
    send_pps(256'h5000);
    total++;
    if (pps_out[3*256 +: 256] !== 256'h5004) begin
      bad++; $display("FAIL flush_recapture: got %h want %h", pps_out[3*256 +: 256], 256'h5004);
    end
  endtask

  task automatic test_reset_mid();
    cfg_chunk_words = 12'd2; cfg_nbr_slices = 2'd2;
    cycle(0, 1, 1, 256'h6000, '1);
    cycle(0, 1, 0, 256'h6001, '1);
    rst_n = 1'b0;
    model_reset();
    #3;
    check_all_zero("reset_mid_outputs");
    @(posedge clk_in_int); #1;
    rst_n = 1'b1;
    send_pps(256'h7000);
    total++;
    if (pps_out[255:0] !== 256'h7001) begin
      bad++; $display("FAIL reset_mid_pps0: got %h want %h", pps_out[255:0], 256'h7001);
    end
  endtask

  task automatic test_random();
    logic f, v, s;
    logic [255:0] d;
    for (int i = 0; i < 600; i++) begin
      f = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) < 8);
      s = ($urandom_range(0, 9) == 0);
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cfg_chunk_words = CW'($urandom_range(0, 4));
      cfg_nbr_slices  = 2'($urandom_range(0, 3));
      cycle(f, v, s, d, MAX'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_pps();
    test_dispatch();
    test_clamp();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
